uart_tx_fifo: RTL

Buffered UART transmitter: the transmit half paired with the UART receiver in the peripheral's serial path. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte as 8N1 frames: start bit, 8 data bits LSB first, stop bit. Bit period is set at run time by the same 16-bit clocks-per-bit value the receiver uses, so both ends share one baud register.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo_buf.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and the paired receiver).
//   tx_state_e : transmit FSM state encoding (3 bits)
//   DATA_BITS  : data bits per frame
//   CPB_W      : width of the clocks-per-bit baud value
//   MIN_CPB    : smallest usable clocks-per-bit value
//   clamp_cpb  : raises a clocks-per-bit value to at least MIN_CPB
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CPB_W     = 16;
  localparam logic [CPB_W-1:0] MIN_CPB = 16'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] v);
    return (v < MIN_CPB) ? MIN_CPB : v;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous byte FIFO feeding the UART transmit shifter.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears pointers)
//   push, wdata   : write wdata when push and not full
//   pop, rdata    : rdata shows the head; pop removes it when not empty
//   full, empty   : occupancy flags
//   level         : number of stored bytes (0..DEPTH)
module uart_tx_fifo_buf #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_L);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes enter a FIFO over valid/ready and leave
// as serial frames (start, 8 data bits LSB first, [parity], stop).
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit (11-bit frames).
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   clks_per_bit_i   : clocks per serial bit, clamped to >= 2, latched per frame
//   tx_data_i        : byte to send
//   tx_valid_i       : tx_data_i valid
//   tx_ready_o       : FIFO not full
//   parity_odd_i     : 1 = odd parity, 0 = even (parity build only)
//   tx_o             : registered serial line, idle high
//   tx_busy_o        : frame in progress
//   tx_done_o        : high during the last cycle of each stop bit
//   fifo_level_o     : bytes buffered, excluding the one in the shifter
//   dbg_state_o      : current FSM state code
// Handshake: a byte is taken on a rising edge where tx_valid_i && tx_ready_o;
// tx_data_i must be stable while tx_valid_i is high and tx_ready_o is low.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CPB_W-1:0] clks_per_bit_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic             parity_odd_i,
  output logic             tx_o,
  output logic             tx_busy_o,
  output logic             tx_done_o,
  output logic [LW-1:0]    fifo_level_o,
  output logic [2:0]       dbg_state_o
);

  tx_state_e        state_q, state_d;
  logic [CPB_W-1:0] cnt_q, cnt_d, cpb_q, cpb_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_d;
  logic             load, pop, last_cyc;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;

  uart_tx_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (tx_valid_i),
    .wdata (tx_data_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte as popped, before shifting destroys it.
  logic par_q, par_d;
`else
  logic unused_parity;
  assign unused_parity = parity_odd_i;
`endif

  assign last_cyc = (cnt_q == cpb_q - 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpb_d   = cpb_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: load = !fifo_empty;
      START: begin
        cnt_d = cnt_q + 16'd1;
        if (last_cyc) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (last_cyc) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_q + 16'd1;
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (last_cyc) begin
          // Next byte goes straight into START so frames abut with no idle bit.
          state_d = IDLE;
          load    = !fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_rdata;
      cpb_d   = clamp_cpb(clks_per_bit_i);
      cnt_d   = '0;
      idx_d   = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = (^fifo_rdata) ^ parity_odd_i;
`endif
    end

    // Line value is derived from the next state so tx_o registers in step
    // with the state and falls on the same edge that enters START.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cpb_q   <= MIN_CPB;
      shift_q <= '0;
      idx_q   <= '0;
      tx_o    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_o    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_ready_o  = !fifo_full;
  assign tx_busy_o   = (state_q != IDLE);
  assign tx_done_o   = (state_q == STOP) && last_cyc;
  assign dbg_state_o = state_q;

endmodule
